// File: rtl/rnoc_pkg.sv
// Shared types and helpers for the mesh router route computation stage.
// Contents: output direction enum, routing mode constants, dimension-order route functions.
// Coordinates are passed zero-extended to CW bits so one function serves every mesh size.
package rnoc_pkg;

    typedef enum logic [2:0] {
        P_LOCAL = 3'd0,
        P_NORTH = 3'd1,
        P_EAST  = 3'd2,
        P_SOUTH = 3'd3,
        P_WEST  = 3'd4
    } port_e;

    localparam int ALGO_XY  = 0;
    localparam int ALGO_YX  = 1;
    localparam int ALGO_ALT = 2;

    localparam int CW = 16;

    // X dimension first; y grows northward.
    function automatic port_e route_xy(input logic [CW-1:0] id_x, input logic [CW-1:0] id_y,
                                       input logic [CW-1:0] dst_x, input logic [CW-1:0] dst_y);
        port_e r;
        if (dst_x > id_x)      r = P_EAST;
        else if (dst_x < id_x) r = P_WEST;
        else if (dst_y > id_y) r = P_NORTH;
        else if (dst_y < id_y) r = P_SOUTH;
        else                   r = P_LOCAL;
        return r;
    endfunction

    // Y dimension first.
    function automatic port_e route_yx(input logic [CW-1:0] id_x, input logic [CW-1:0] id_y,
                                       input logic [CW-1:0] dst_x, input logic [CW-1:0] dst_y);
        port_e r;
        if (dst_y > id_y)      r = P_NORTH;
        else if (dst_y < id_y) r = P_SOUTH;
        else if (dst_x > id_x) r = P_EAST;
        else if (dst_x < id_x) r = P_WEST;
        else                   r = P_LOCAL;
        return r;
    endfunction

endpackage

// File: rtl/rc_port.sv
// Per-input-port route computation: latches a route on a head flit, holds it until the tail fires.
// Ports: clk/rst, router id, flit front status (valid/head/tail/fire), head destination,
//        registered route_valid/route_sel and 1-cycle err_dst/err_proto pulses (1-cycle latency).
module rc_port
    import rnoc_pkg::*;
#(
    parameter int X_SIZE = 4,
    parameter int Y_SIZE = 4,
    parameter int ALGO   = 0,
    parameter int XW     = 2,
    parameter int YW     = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [XW-1:0] id_x,
    input  logic [YW-1:0] id_y,
    input  logic          in_valid,
    input  logic          in_head,
    input  logic          in_tail,
    input  logic          in_fire,
    input  logic [XW-1:0] dst_x,
    input  logic [YW-1:0] dst_y,
    output logic          route_valid,
    output port_e         route_sel,
    output logic          err_dst,
    output logic          err_proto
);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_e;

    state_e state_q, state_d;
    port_e  route_q, route_d;
    logic   alt_q, alt_d;
    logic   err_dst_d, err_proto_d;
    logic   oob;
    logic   use_yx;
    port_e  route_calc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            route_q   <= P_LOCAL;
            alt_q     <= 1'b0;
            err_dst   <= 1'b0;
            err_proto <= 1'b0;
        end else begin
            state_q   <= state_d;
            route_q   <= route_d;
            alt_q     <= alt_d;
            err_dst   <= err_dst_d;
            err_proto <= err_proto_d;
        end
    end

    always_comb begin
        oob        = (32'(dst_x) >= 32'(X_SIZE)) || (32'(dst_y) >= 32'(Y_SIZE));
        use_yx     = (ALGO == ALGO_YX) || ((ALGO == ALGO_ALT) && alt_q);
        route_calc = use_yx ? route_yx(CW'(id_x), CW'(id_y), CW'(dst_x), CW'(dst_y))
                            : route_xy(CW'(id_x), CW'(id_y), CW'(dst_x), CW'(dst_y));

        state_d     = state_q;
        route_d     = route_q;
        alt_d       = alt_q;
        err_dst_d   = 1'b0;
        err_proto_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid && in_head) begin
                    state_d   = ACTIVE;
                    // Unroutable destinations drain to the local port.
                    route_d   = oob ? P_LOCAL : route_calc;
                    err_dst_d = oob;
                    if (ALGO == ALGO_ALT) alt_d = ~alt_q;
                end else if (in_valid) begin
                    err_proto_d = 1'b1;
                end
            end
            ACTIVE: begin
                if (in_valid && in_fire && in_tail) begin
                    state_d = IDLE;
                end else if (in_valid && in_head) begin
                    err_proto_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign route_valid = (state_q == ACTIVE);
    assign route_sel   = route_q;

endmodule

// File: rtl/rc_seq.sv
// Registered route computation for all router input ports (one independent rc_port each).
// Ports: clk/rst, router id, per-port flit status and head destination vectors,
//        per-port route_valid/route_sel (1 cycle after head) and err_dst/err_proto pulses.
module rc_seq
    import rnoc_pkg::*;
#(
    parameter int X_SIZE    = 4,
    parameter int Y_SIZE    = 4,
    parameter int NUM_PORTS = 5,
    parameter int ALGO      = 0,
    localparam int XW = ($clog2(X_SIZE) > 1) ? $clog2(X_SIZE) : 1,
    localparam int YW = ($clog2(Y_SIZE) > 1) ? $clog2(Y_SIZE) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [XW-1:0]                  id_x,
    input  logic [YW-1:0]                  id_y,
    input  logic [NUM_PORTS-1:0]           in_valid,
    input  logic [NUM_PORTS-1:0]           in_head,
    input  logic [NUM_PORTS-1:0]           in_tail,
    input  logic [NUM_PORTS-1:0]           in_fire,
    input  logic [NUM_PORTS-1:0][XW-1:0]   dst_x,
    input  logic [NUM_PORTS-1:0][YW-1:0]   dst_y,
    output logic [NUM_PORTS-1:0]           route_valid,
    output port_e [NUM_PORTS-1:0]          route_sel,
    output logic [NUM_PORTS-1:0]           err_dst,
    output logic [NUM_PORTS-1:0]           err_proto
);

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        rc_port #(
            .X_SIZE (X_SIZE),
            .Y_SIZE (Y_SIZE),
            .ALGO   (ALGO),
            .XW     (XW),
            .YW     (YW)
        ) u_port (
            .clk         (clk),
            .rst         (rst),
            .id_x        (id_x),
            .id_y        (id_y),
            .in_valid    (in_valid[g]),
            .in_head     (in_head[g]),
            .in_tail     (in_tail[g]),
            .in_fire     (in_fire[g]),
            .dst_x       (dst_x[g]),
            .dst_y       (dst_y[g]),
            .route_valid (route_valid[g]),
            .route_sel   (route_sel[g]),
            .err_dst     (err_dst[g]),
            .err_proto   (err_proto[g])
        );
    end

endmodule

// File: tb/tb_rc_seq.sv
// Directed bench for rc_seq: an XY instance on a 5x4 mesh and an alternating-mode 4x4 instance.
// Inputs change 1 time unit after the rising edge; outputs are checked at that same point.
// Every check is an immediate assertion that counts and reports miscompares.
module tb_rc_seq;
    import rnoc_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Instance A: X_SIZE=5 (XW=3), Y_SIZE=4 (YW=2), XY routing.
    logic [2:0]       a_id_x;
    logic [1:0]       a_id_y;
    logic [4:0]       a_valid, a_head, a_tail, a_fire;
    logic [4:0][2:0]  a_dst_x;
    logic [4:0][1:0]  a_dst_y;
    logic [4:0]       a_rv, a_edst, a_eproto;
    port_e [4:0]      a_sel;

    // Instance B: 4x4 mesh, alternating XY/YX.
    logic [1:0]       b_id_x, b_id_y;
    logic [4:0]       b_valid, b_head, b_tail, b_fire;
    logic [4:0][1:0]  b_dst_x, b_dst_y;
    logic [4:0]       b_rv, b_edst, b_eproto;
    port_e [4:0]      b_sel;

    rc_seq #(.X_SIZE(5), .Y_SIZE(4), .NUM_PORTS(5), .ALGO(0)) u_a (
        .clk(clk), .rst(rst), .id_x(a_id_x), .id_y(a_id_y),
        .in_valid(a_valid), .in_head(a_head), .in_tail(a_tail), .in_fire(a_fire),
        .dst_x(a_dst_x), .dst_y(a_dst_y),
        .route_valid(a_rv), .route_sel(a_sel), .err_dst(a_edst), .err_proto(a_eproto)
    );

    rc_seq #(.X_SIZE(4), .Y_SIZE(4), .NUM_PORTS(5), .ALGO(2)) u_b (
        .clk(clk), .rst(rst), .id_x(b_id_x), .id_y(b_id_y),
        .in_valid(b_valid), .in_head(b_head), .in_tail(b_tail), .in_fire(b_fire),
        .dst_x(b_dst_x), .dst_y(b_dst_y),
        .route_valid(b_rv), .route_sel(b_sel), .err_dst(b_edst), .err_proto(b_eproto)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic a_idle();
        a_valid = '0; a_head = '0; a_tail = '0; a_fire = '0;
    endtask

    task automatic a_flit(input int p, input logic h, input logic t, input logic f,
                          input logic [2:0] dx, input logic [1:0] dy);
        a_valid[p] = 1'b1; a_head[p] = h; a_tail[p] = t; a_fire[p] = f;
        a_dst_x[p] = dx;   a_dst_y[p] = dy;
    endtask

    initial begin
        rst = 1'b1;
        a_id_x = 3'd1; a_id_y = 2'd1; b_id_x = 2'd1; b_id_y = 2'd1;
        a_idle(); a_dst_x = '0; a_dst_y = '0;
        b_valid = '0; b_head = '0; b_tail = '0; b_fire = '0; b_dst_x = '0; b_dst_y = '0;
        tick(); tick();

        // Reset state
        chk("rst_a_rv",     32'(a_rv),     32'h0);
        chk("rst_a_sel0",   32'(a_sel[0]), 32'(P_LOCAL));
        chk("rst_a_err",    32'({a_edst, a_eproto}), 32'h0);
        chk("rst_b_rv",     32'(b_rv),     32'h0);
        rst = 1'b0;

        // 1: head to (3,0) from (1,1) -> EAST one cycle later; holds through body; drops after tail
        a_flit(0, 1, 0, 1, 3'd3, 2'd0);
        tick();
        chk("t1_rv_head",  32'(a_rv[0]),  32'h1);
        chk("t1_sel_head", 32'(a_sel[0]), 32'(P_EAST));
        chk("t1_nodst",    32'(a_edst[0]), 32'h0);
        a_flit(0, 0, 0, 1, 3'd0, 2'd3);
        tick();
        chk("t1_rv_body",  32'(a_rv[0]),  32'h1);
        chk("t1_sel_body", 32'(a_sel[0]), 32'(P_EAST));
        a_flit(0, 0, 1, 1, 3'd0, 2'd0);
        tick();
        chk("t1_rv_tail",  32'(a_rv[0]),  32'h0);
        a_idle();

        // 3: dst equals id -> LOCAL; then dst_x=5 out of range -> err_dst pulse, LOCAL
        a_flit(0, 1, 1, 0, 3'd1, 2'd1);
        tick();
        chk("t3_local_sel", 32'(a_sel[0]), 32'(P_LOCAL));
        chk("t3_local_rv",  32'(a_rv[0]),  32'h1);
        a_flit(0, 1, 1, 1, 3'd1, 2'd1);
        tick();
        chk("t3_local_done", 32'(a_rv[0]), 32'h0);
        a_flit(0, 1, 0, 1, 3'd5, 2'd0);
        tick();
        chk("t3_oob_err",  32'(a_edst[0]), 32'h1);
        chk("t3_oob_sel",  32'(a_sel[0]),  32'(P_LOCAL));
        chk("t3_oob_rv",   32'(a_rv[0]),   32'h1);
        a_idle();
        tick();
        chk("t3_oob_pulse", 32'(a_edst[0]), 32'h0);
        a_flit(0, 0, 1, 1, 3'd0, 2'd0);
        tick();
        chk("t3_oob_done", 32'(a_rv[0]), 32'h0);
        a_idle();

        // 4: body in IDLE -> err_proto, stays idle; head during ACTIVE -> err_proto, route kept
        a_flit(1, 0, 0, 1, 3'd0, 2'd0);
        tick();
        chk("t4_idle_body_err", 32'(a_eproto[1]), 32'h1);
        chk("t4_idle_body_rv",  32'(a_rv[1]),     32'h0);
        a_idle();
        tick();
        chk("t4_err_pulse", 32'(a_eproto[1]), 32'h0);
        a_flit(1, 1, 0, 1, 3'd0, 2'd1);
        tick();
        chk("t4_west", 32'(a_sel[1]), 32'(P_WEST));
        a_flit(1, 1, 0, 0, 3'd3, 2'd3);
        tick();
        chk("t4_act_head_err", 32'(a_eproto[1]), 32'h1);
        chk("t4_act_head_sel", 32'(a_sel[1]),    32'(P_WEST));
        chk("t4_act_head_rv",  32'(a_rv[1]),     32'h1);
        a_flit(1, 0, 1, 1, 3'd0, 2'd0);
        tick();
        chk("t4_done", 32'(a_rv[1]), 32'h0);
        a_idle();

        // 5: single-flit packet, then immediate next head -> 1-cycle bubble
        a_flit(2, 1, 1, 0, 3'd1, 2'd3);
        tick();
        chk("t5_north", 32'(a_sel[2]), 32'(P_NORTH));
        chk("t5_rv1",   32'(a_rv[2]),  32'h1);
        a_flit(2, 1, 1, 1, 3'd1, 2'd3);
        tick();
        chk("t5_bubble_rv",  32'(a_rv[2]),     32'h0);
        chk("t5_bubble_err", 32'(a_eproto[2]), 32'h0);
        a_flit(2, 1, 0, 1, 3'd1, 2'd0);
        tick();
        chk("t5_next_rv",  32'(a_rv[2]),  32'h1);
        chk("t5_next_sel", 32'(a_sel[2]), 32'(P_SOUTH));
        a_flit(2, 0, 1, 1, 3'd0, 2'd0);
        tick();
        chk("t5_done", 32'(a_rv[2]), 32'h0);
        a_idle();

        // 6: ports 0 and 3 active together, port 0 traffic leaves port 3 alone, then mid-packet reset
        a_flit(0, 1, 0, 1, 3'd3, 2'd2);
        tick();
        a_idle();
        a_flit(3, 1, 0, 1, 3'd1, 2'd2);
        tick();
        a_idle();
        a_flit(0, 0, 0, 1, 3'd0, 2'd0);
        tick();
        chk("t6_p0_sel", 32'(a_sel[0]), 32'(P_EAST));
        chk("t6_p3_sel", 32'(a_sel[3]), 32'(P_NORTH));
        chk("t6_rv",     32'(a_rv),     32'h09);
        rst = 1'b1;
        tick();
        chk("t6_rst_rv",   32'(a_rv),     32'h0);
        chk("t6_rst_sel0", 32'(a_sel[0]), 32'(P_LOCAL));
        chk("t6_rst_sel3", 32'(a_sel[3]), 32'(P_LOCAL));
        chk("t6_rst_err",  32'({a_edst, a_eproto}), 32'h0);
        rst = 1'b0;
        tick();
        chk("t6_post_body_err", 32'(a_eproto), 32'h01);
        a_idle();
        tick();

        // 2: alternating mode, three packets (2,2) from (1,1) on port 4 -> EAST, NORTH, EAST
        for (int k = 0; k < 3; k++) begin
            b_valid[4] = 1'b1; b_head[4] = 1'b1; b_tail[4] = 1'b0; b_fire[4] = 1'b1;
            b_dst_x[4] = 2'd2; b_dst_y[4] = 2'd2;
            tick();
            chk($sformatf("t2_alt_pkt%0d", k), 32'(b_sel[4]),
                (k == 1) ? 32'(P_NORTH) : 32'(P_EAST));
            chk($sformatf("t2_alt_rv%0d", k), 32'(b_rv[4]), 32'h1);
            b_head[4] = 1'b0; b_tail[4] = 1'b1;
            tick();
            b_valid[4] = 1'b0; b_fire[4] = 1'b0; b_tail[4] = 1'b0;
            tick();
        end
        chk("t2_other_ports", 32'(b_rv), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
